// File: rtl/risc_spm_pkg.sv
// Shared RISC-SPM definitions: opcode constants and the fetch sequencer state encoding.
// Pure declarations; no latency or flow control of its own.
package risc_spm_pkg;

  localparam logic [3:0] BR   = 4'b1000;
  localparam logic [3:0] BRZ  = 4'b1001;
  localparam logic [3:0] HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FET,
    S_DEC,
    S_BR,
    S_ISSUE,
    S_HALT
  } state_t;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: strobes the PC, reads instructions, resolves BR/BRZ, issues the rest to decode.
// Latency: non-branch reaches ir_valid in the 3rd cycle after S_FET entry; a branch returns to S_FET in 4.
// Backpressure: mem_ready stalls S_FET/S_BR, ir_ready stalls S_ISSUE. BRANCH_STATS_EN adds branch_count.
module pc_fetch_sequencer
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [WORD_SIZE-1:0] pc_count,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [WORD_SIZE-1:0] pc_data,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 zero_flag,
  output logic [WORD_SIZE-1:0] ir,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic                 halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]          branch_count
`endif
);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [3:0]           opcode;
  logic                 taken;

  assign opcode   = ir_q[WORD_SIZE-1:WORD_SIZE-4];
  assign pc_data  = mem_rdata;
  assign mem_addr = pc_count;
  assign ir       = ir_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count_q, branch_count_d;
  assign branch_count = branch_count_q;
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    Load_PC  = 1'b0;
    Inc_PC   = 1'b0;
    mem_rd   = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    taken    = (opcode == BR) || ((opcode == BRZ) && zero_flag);
`ifdef BRANCH_STATS_EN
    branch_count_d = branch_count_q;
`endif
    // Strobes are suppressed under reset so an in-flight read cannot move the PC.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (run) state_d = S_FET;
        end
        S_FET: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_d    = mem_rdata;
            Inc_PC  = 1'b1;
            state_d = S_DEC;
          end
        end
        S_DEC: begin
          if (opcode == HALT)                       state_d = S_HALT;
          else if ((opcode == BR) || (opcode == BRZ)) state_d = S_BR;
          else                                      state_d = S_ISSUE;
        end
        S_BR: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            Load_PC = taken;
            Inc_PC  = !taken;
            state_d = S_FET;
`ifdef BRANCH_STATS_EN
            if (taken && (branch_count_q != 16'hFFFF))
              branch_count_d = branch_count_q + 16'd1;
`endif
          end
        end
        S_ISSUE: begin
          ir_valid = 1'b1;
          if (ir_ready) state_d = S_FET;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
`ifdef BRANCH_STATS_EN
      branch_count_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef BRANCH_STATS_EN
      branch_count_q <= branch_count_d;
`endif
    end
  end

endmodule
